// File: rtl/pipes_pkg.sv
// Shared types and constants for the instruction-fetch pipeline slice.
// FETCH_JAL_PRED_EN (optional) enables static JAL-follow prediction in fetch_pc_sel.
package pipes_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEF = 64'h0000_0000_8000_0000;
  localparam logic [6:0]      OPC_JAL      = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
  } fetch_out_t;

  function automatic logic is_jal(input logic [ILEN-1:0] instr);
    return instr[6:0] == OPC_JAL;
  endfunction

  // J-type immediate, sign-extended to XLEN
  function automatic logic [XLEN-1:0] jal_offset(input logic [ILEN-1:0] instr);
    logic [20:0] imm;
    imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return {{(XLEN-21){imm[20]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-fetch-address select: redirect, JAL target or sequential +4.
// JAL-follow prediction is present only when FETCH_JAL_PRED_EN is defined.
module fetch_pc_sel
  import pipes_pkg::*;
(
  input  logic [XLEN-1:0] out_pc,
  input  logic [ILEN-1:0] out_instr,
  input  logic [ILEN-1:0] resp_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] target_c,
  output logic            resp_jal_c
);

  logic [XLEN-1:0] seq_pc_c;
  logic            unused_lsb_c;

`ifdef FETCH_JAL_PRED_EN
  always_comb begin
    seq_pc_c = out_pc + XLEN'(4);
    if (is_jal(out_instr)) seq_pc_c = out_pc + jal_offset(out_instr);
  end
  assign resp_jal_c = is_jal(resp_instr);
`else
  logic unused_instr_c;
  assign seq_pc_c       = out_pc + XLEN'(4);
  assign resp_jal_c     = 1'b0;
  assign unused_instr_c = ^{out_instr, resp_instr};
`endif

  // Redirect targets are word aligned; the low two bits are ignored
  assign target_c     = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : seq_pc_c;
  assign unused_lsb_c = ^redirect_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one bus request in flight and hands
// {pc, instr} to decode. Optional FETCH_JAL_PRED_EN follows JAL targets.
module fetch_unit
  import pipes_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            pred_taken
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            ireq_valid_q, ireq_valid_d;
  fetch_out_t      out_q, out_d;

  logic [XLEN-1:0] target_c;
  logic            resp_jal_c;

  fetch_pc_sel u_pc_sel (
    .out_pc         (out_q.pc),
    .out_instr      (out_q.instr),
    .resp_instr     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .target_c       (target_c),
    .resp_jal_c     (resp_jal_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      req_addr_q   <= '0;
      ireq_valid_q <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      ireq_valid_q <= ireq_valid_d;
      out_q        <= out_d;
    end
  end

  // Next-state, PC and output-register update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;

    unique case (state_q)
      IDLE: begin
        state_d    = REQ;
        req_addr_d = pc_q;
      end
      REQ: begin
        if (iresp_data_ok && redirect_valid) begin
          pc_d       = target_c;
          req_addr_d = target_c;
        end else if (iresp_data_ok) begin
          out_d.pc         = req_addr_q;
          out_d.instr      = iresp_data;
          out_d.pred_taken = resp_jal_c;
          state_d          = HOLD;
        end else if (redirect_valid) begin
          pc_d    = target_c;
          state_d = DROP;
        end
      end
      DROP: begin
        // The old request is still in flight; its word is thrown away
        if (redirect_valid) pc_d = target_c;
        if (iresp_data_ok) begin
          req_addr_d = redirect_valid ? target_c : pc_q;
          state_d    = REQ;
        end
      end
      HOLD: begin
        if (redirect_valid || out_ready) begin
          pc_d             = target_c;
          req_addr_d       = target_c;
          out_d.pred_taken = 1'b0;
          state_d          = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    out_d.valid  = (state_d == HOLD);
    ireq_valid_d = (state_d == REQ) || (state_d == DROP);
  end

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = req_addr_q;
  assign out_valid  = out_q.valid;
  assign out_pc     = out_q.pc;
  assign out_instr  = out_q.instr;
  assign pred_taken = out_q.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/stall/redirect/JAL/wrap scenarios.
// Expectations follow FETCH_JAL_PRED_EN when it is defined for the build.
module tb_fetch_unit;
  import pipes_pkg::*;

  logic            clk;
  logic            reset;
  logic            ireq_valid;
  logic [63:0]     ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_pc;
  logic [31:0]     out_instr;
  logic            redirect_valid;
  logic [63:0]     redirect_pc;
  logic            pred_taken;

  int checks   = 0;
  int failures = 0;

  fetch_out_t exp_q[$];

`ifdef FETCH_JAL_PRED_EN
  localparam logic        JAL_PRED = 1'b1;
  localparam logic [63:0] JAL_NEXT = 64'h0000_0000_8000_0110;
`else
  localparam logic        JAL_PRED = 1'b0;
  localparam logic [63:0] JAL_NEXT = 64'h0000_0000_8000_0104;
`endif

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pred_taken     (pred_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input string name, input logic [63:0] exp_addr);
    for (int i = 0; i < 20 && !ireq_valid; i++) tick();
    check({name, "_req_seen"}, 64'(ireq_valid), 64'd1);
    check({name, "_addr"}, ireq_addr, exp_addr);
  endtask

  task automatic respond(input string name, input logic [31:0] data, input int delay);
    logic [63:0] addr;
    addr = ireq_addr;
    for (int i = 0; i < delay; i++) begin
      tick();
      check({name, "_addr_stable"}, ireq_addr, addr);
    end
    iresp_data_ok = 1'b1;
    iresp_data    = data;
    tick();
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
  endtask

  task automatic expect_out(input logic [63:0] pc, input logic [31:0] instr, input logic pred);
    fetch_out_t e;
    e.valid      = 1'b1;
    e.pc         = pc;
    e.instr      = instr;
    e.pred_taken = pred;
    exp_q.push_back(e);
  endtask

  // Monitor: every newly presented word must match the oldest expected entry
  initial begin
    logic prev_v;
    fetch_out_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got pc %h instr %h, expected no output", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          check("mon_pc", out_pc, e.pc);
          check("mon_instr", 64'(out_instr), 64'(e.instr));
          check("mon_pred", 64'(pred_taken), 64'(e.pred_taken));
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    reset          = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // 1: reset and first request
    repeat (3) tick();
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_pred", 64'(pred_taken), 64'd0);
    reset = 1'b1;
    check("idle_ireq_valid", 64'(ireq_valid), 64'd0);
    tick();
    check("first_req_valid", 64'(ireq_valid), 64'd1);
    check("first_req_addr", ireq_addr, 64'h8000_0000);

    // 2: fetch with two-cycle memory latency, decode ready
    expect_out(64'h8000_0000, 32'h0010_0093, 1'b0);
    respond("t2", 32'h0010_0093, 2);
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_no_req_in_hold", 64'(ireq_valid), 64'd0);
    tick();
    check("t2_out_valid_one_cycle", 64'(out_valid), 64'd0);
    wait_req("t2_next", 64'h8000_0004);

    // 3: downstream stall for five cycles
    out_ready = 1'b0;
    expect_out(64'h8000_0004, 32'h0020_8113, 1'b0);
    respond("t3", 32'h0020_8113, 0);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", 64'(out_valid), 64'd1);
      check("t3_stall_pc", out_pc, 64'h8000_0004);
      check("t3_stall_instr", 64'(out_instr), 64'h0020_8113);
      check("t3_stall_no_req", 64'(ireq_valid), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    wait_req("t3_next", 64'h8000_0008);

    // 4: redirect while a request is pending
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    check("t4_drop_valid", 64'(ireq_valid), 64'd1);
    check("t4_drop_addr", ireq_addr, 64'h8000_0008);
    respond("t4", 32'hdead_beef, 1);
    check("t4_no_out", 64'(out_valid), 64'd0);
    wait_req("t4_next", 64'h8000_0100);

    // 5a: redirect coincident with data_ok, unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0202;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'hbad0_0bad;
    tick();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    check("t5a_no_out", 64'(out_valid), 64'd0);
    wait_req("t5a_next", 64'h8000_0200);

    // 5b: redirect wins over out_ready while holding a word
    out_ready = 1'b0;
    expect_out(64'h8000_0200, 32'h0000_0013, 1'b0);
    respond("t5b", 32'h0000_0013, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t5b_out_dropped", 64'(out_valid), 64'd0);
    wait_req("t5b_next", 64'h8000_0100);

    // 6: JAL +16
    expect_out(64'h8000_0100, 32'h0100_006f, JAL_PRED);
    respond("t6", 32'h0100_006f, 0);
    tick();
    wait_req("t6_next", JAL_NEXT);

    // 7: sequential fetch wraps from the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hffff_ffff_ffff_fffc;
    iresp_data_ok  = 1'b1;
    tick();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    wait_req("t7_top", 64'hffff_ffff_ffff_fffc);
    expect_out(64'hffff_ffff_ffff_fffc, 32'h0000_0013, 1'b0);
    respond("t7", 32'h0000_0013, 0);
    tick();
    wait_req("t7_wrap", 64'h0);

    // 8: reset mid-request with a stray data_ok
    reset         = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1234_5678;
    tick();
    reset         = 1'b1;
    iresp_data_ok = 1'b0;
    check("t8_req_dropped", 64'(ireq_valid), 64'd0);
    check("t8_no_out", 64'(out_valid), 64'd0);
    tick();
    check("t8_restart_addr", ireq_addr, 64'h8000_0000);

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
